urisc_io_master: RTL and testbench
==================================

// Module: urisc_io_master
// PURPOSE
//  External-side controller for the urisc cycle-stealing IO port. It turns word-stream commands
//  (load a block into processor memory / dump a block out of it) into ioAddress/ioBusDirection/ioBus
//  traffic, one word per ioClk slot. It sits between a host (loader, debugger, testbench) and urisc.
// PARAMETERS
//  WORD_SIZE  gc::WORD_SIZE  width of data, address, length
//  DEPTH      4              entries in each of the write and read data FIFOs (power of 2, >=2)
// PORTS
//  clk             in   1          same clock as urisc
//  rst             in   1          asynchronous, active-low reset
//  cmd_valid       in   1          command request
//  cmd_ready       out  1          command accepted when cmd_valid & cmd_ready
//  cmd_write       in   1          1 = host->memory (load), 0 = memory->host (dump)
//  cmd_base        in   WORD_SIZE  first memory address
//  cmd_len         in   WORD_SIZE  number of words (0 allowed)
//  wr_valid/wr_ready in/out 1      host write-data stream handshake
//  wr_data         in   WORD_SIZE  word to store
//  rd_valid/rd_ready out/in 1      host read-data stream handshake
//  rd_data         out  WORD_SIZE  word read back
//  busy            out  1          command in progress
//  done            out  1          one-cycle pulse at command completion
//  ioClk           in   1          slot strobe from urisc
//  ioAddress       out  WORD_SIZE  memory address for the current slot
//  ioBusDirection  out  1          gc::IO_IN = write memory, gc::IO_OUT = read memory
//  ioBus           inout WORD_SIZE driven only when ioBusDirection==gc::IO_IN, else 'z
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE, cmd_ready=1, busy=0, done=0, rd_valid=0, wr_ready=0,
//    ioAddress=0, ioBusDirection=gc::IO_OUT, ioBus='z, both FIFOs emptied, counters 0.
//  - Slot: a clk cycle where registered ioClk is 1 and its previous registered value was 0.
//  - FSM IDLE -> WR | RD -> IDLE. IDLE: cmd_ready=1; on accept latch base/len/write, cmd_ready=0.
//    cmd_len==0: no IO activity, done pulses the next cycle, stay IDLE, busy stays 0.
//  - WR: wr_ready = !wfifo_full && (words accepted < len). ioAddress = base+idx (mod 2^WORD_SIZE).
//    If wfifo nonempty: ioBusDirection=IO_IN, ioBus=wfifo head; at a slot, pop and idx++.
//    If wfifo empty: ioBusDirection=IO_OUT, ioBus='z (slot consumed, no memory write).
//    After idx==len: next cycle direction=IO_OUT, ioBus='z, done=1 for 1 cycle, -> IDLE.
//  - RD: ioBusDirection=IO_OUT always, ioBus='z. Each word uses two slots: address (base+idx) held
//    for slot A (presentation) and slot B; on slot B capture ioBus into rfifo, idx++.
//    If rfifo full at slot B, do not capture; address stays, capture retried on next slot.
//    rd_valid = rfifo nonempty; pop on rd_valid & rd_ready. done pulses when last word is
//    captured (rfifo may still hold data); busy=0 in the same cycle done asserts.
//  - Simultaneous push/pop on a FIFO in one cycle is allowed, including when full or empty.
//  - Mid-command reset: immediate abort, outputs to reset values, no done pulse.
//  - cmd_valid while busy is ignored (cmd_ready=0); no command queuing.
//  - Address arithmetic is unsigned, WORD_SIZE bits, wraps from all-ones to 0.
// TESTING
//  1 Write len=3 base=20, data 5,6,7 preloaded, ioClk every 3 clk -> 3 slots with IO_IN at 20,21,22
//    carrying 5,6,7; done 1 cycle after third slot; urisc memory holds 5,6,7.
//  2 Read len=2 base=20 after test 1, rd_ready=1 -> rd_data 5 then 6, 4 slots used, done once.
//  3 Write len=2 with wr_valid delayed 3 slots -> those slots show IO_OUT with ioBus='z, then two
//    IO_IN slots; no spurious memory write.
//  4 Read len=6 base=all-ones, DEPTH=4, rd_ready=0 -> addresses wrap to 0..4; stall after 4
//    captures; release rd_ready -> all 6 words delivered in order.
//  5 cmd_len=0 -> done pulse next cycle, ioBusDirection stays IO_OUT, no slot used.
//  6 rst low during second word of a write -> ioBus='z, busy=0, no done; new command runs cleanly.

Source files
------------

// File: rtl/urisc_io_master_if.sv
// urisc_io_master_if: host command/data streams plus urisc IO slot signals.
interface urisc_io_master_if #(parameter int WORD_SIZE = 16);
  logic                 cmd_valid, cmd_ready, cmd_write;
  logic [WORD_SIZE-1:0] cmd_base, cmd_len;
  logic                 wr_valid, wr_ready;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 rd_valid, rd_ready;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 busy, done, io_clk, io_bus_direction;
  logic [WORD_SIZE-1:0] io_address;
  modport master (
    input  cmd_valid, cmd_write, cmd_base, cmd_len, wr_valid, wr_data, rd_ready, io_clk,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, io_address, io_bus_direction
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_base, cmd_len, wr_valid, wr_data, rd_ready, io_clk,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, io_address, io_bus_direction
  );
endinterface

// File: rtl/urisc_io_master.sv
// urisc_io_master: turns host load/dump block commands into urisc cycle-stealing IO slot traffic,
// buffering host data through small write and read FIFOs.
module urisc_io_master #(
  parameter int   WORD_SIZE = 16,
  parameter int   DEPTH     = 4,
  parameter logic IO_IN     = 1'b1,
  parameter logic IO_OUT    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  urisc_io_master_if.master    bus,
  inout  wire  [WORD_SIZE-1:0] io_bus_io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);
  localparam logic [AW:0] FULL_GAP = {1'b1, {AW{1'b0}}};
  typedef enum logic [1:0] {IDLE, WR, RD} state_e;
  state_e               state_q;
  logic [WORD_SIZE-1:0] len_q, idx_q, acc_q, addr_q;
  logic                 io_clk_q, io_clk_p_q, phase_q, done_q;
  logic [AW:0]          wwp_q, wrp_q, rwp_q, rrp_q;
  logic [WORD_SIZE-1:0] wmem_q [DEPTH];
  logic [WORD_SIZE-1:0] rmem_q [DEPTH];
  logic slot, w_empty, w_full, r_empty, r_full, w_push, w_pop, r_push, r_pop, last, drive;
  assign slot    = io_clk_q & ~io_clk_p_q;
  assign w_empty = wwp_q == wrp_q;
  assign w_full  = (wwp_q ^ wrp_q) == FULL_GAP;
  assign r_empty = rwp_q == rrp_q;
  assign r_full  = (rwp_q ^ rrp_q) == FULL_GAP;
  assign last    = idx_q + ONE == len_q;
  assign drive   = state_q == WR && !w_empty;
  assign w_push  = bus.wr_valid & bus.wr_ready;
  assign w_pop   = drive & slot;
  assign r_pop   = bus.rd_valid & bus.rd_ready;
  // slot B capture may proceed into a full FIFO when a host pop frees an entry this cycle
  assign r_push  = state_q == RD && slot && phase_q && (!r_full || r_pop);
  assign bus.cmd_ready        = state_q == IDLE;
  assign bus.busy             = state_q != IDLE;
  assign bus.done             = done_q;
  assign bus.wr_ready         = state_q == WR && !w_full && acc_q != len_q;
  assign bus.rd_valid         = !r_empty;
  assign bus.rd_data          = rmem_q[rrp_q[AW-1:0]];
  assign bus.io_address       = addr_q;
  assign bus.io_bus_direction = drive ? IO_IN : IO_OUT;
  assign io_bus_io            = drive ? wmem_q[wrp_q[AW-1:0]] : 'z;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      addr_q     <= '0;
      io_clk_q   <= 1'b0;
      io_clk_p_q <= 1'b0;
      phase_q    <= 1'b0;
      done_q     <= 1'b0;
      wwp_q      <= '0;
      wrp_q      <= '0;
      rwp_q      <= '0;
      rrp_q      <= '0;
    end else begin
      io_clk_q   <= bus.io_clk;
      io_clk_p_q <= io_clk_q;
      done_q     <= 1'b0;
      wwp_q      <= wwp_q + {{AW{1'b0}}, w_push};
      wrp_q      <= wrp_q + {{AW{1'b0}}, w_pop};
      rwp_q      <= rwp_q + {{AW{1'b0}}, r_push};
      rrp_q      <= rrp_q + {{AW{1'b0}}, r_pop};
      case (state_q)
        IDLE: if (bus.cmd_valid) begin
          len_q   <= bus.cmd_len;
          addr_q  <= bus.cmd_base;
          idx_q   <= '0;
          acc_q   <= '0;
          phase_q <= 1'b0;
          if (bus.cmd_len == '0) done_q <= 1'b1;
          else state_q <= bus.cmd_write ? WR : RD;
        end
        WR: begin
          if (w_push) acc_q <= acc_q + ONE;
          if (w_pop) begin
            idx_q  <= idx_q + ONE;
            addr_q <= addr_q + ONE;
            if (last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        RD: if (slot) begin
          if (!phase_q) phase_q <= 1'b1;
          else if (r_push) begin
            phase_q <= 1'b0;
            idx_q   <= idx_q + ONE;
            addr_q  <= addr_q + ONE;
            if (last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  always_ff @(posedge clk) begin
    if (w_push) wmem_q[wwp_q[AW-1:0]] <= bus.wr_data;
    if (r_push) rmem_q[rwp_q[AW-1:0]] <= io_bus_io;
  end
endmodule

// File: tb/tb_urisc_io_master.sv
// tb_urisc_io_master: randomized scoreboard bench with a urisc memory model on the IO slot bus.
module tb_urisc_io_master;
  localparam int   W      = 16;
  localparam int   DEPTH  = 4;
  localparam logic IO_IN  = 1'b1;
  localparam logic IO_OUT = 1'b0;
  typedef logic [W-1:0] word_t;
  typedef struct packed { word_t a; word_t d; } io_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire [W-1:0] io_bus;
  urisc_io_master_if #(.WORD_SIZE(W)) bus();
  urisc_io_master #(.WORD_SIZE(W), .DEPTH(DEPTH), .IO_IN(IO_IN), .IO_OUT(IO_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master), .io_bus_io(io_bus)
  );
  always #5 clk = ~clk;

  word_t mem [65536];
  word_t ref_mem [65536];
  word_t exp_rd [$];
  io_t   exp_io [$];
  int    exp_done [$];
  int    n_checks = 0, n_fail = 0, cyc = 0, slot_cnt = 0, last_in_cyc = 0;
  int    io_period = 3, rd_mode = 1;
  logic  cur_write = 1'b0, s1 = 1'b0, s2 = 1'b0;

  assign io_bus = (bus.io_bus_direction == IO_OUT) ? mem[bus.io_address] : 'z;

  function automatic word_t init_val(int a);
    return word_t'(a * 40503 ^ 23130);
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_wr_ready"}, bus.wr_ready, 0);
    chk({tag, "_io_address"}, bus.io_address, 0);
    chk({tag, "_io_dir"}, bus.io_bus_direction, IO_OUT);
  endtask

  // Slot detection as urisc sees it: registered ioClk rising
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.io_clk;
      s2 <= s1;
    end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int c;
    c = 0;
    bus.io_clk = 1'b0;
    bus.rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c = (c + 1) % io_period;
      bus.io_clk = (c == 0);
      bus.rd_ready = (rd_mode == 2) ? 1'($urandom_range(0, 1)) : (rd_mode == 1);
    end
  end

  // Monitor: urisc memory side effects plus scoreboard pops
  initial begin
    io_t e;
    for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (s1 && !s2 && bus.busy) slot_cnt++;
      if (s1 && !s2 && bus.io_bus_direction == IO_IN) begin
        mem[bus.io_address] = io_bus;
        last_in_cyc = cyc;
        chk("io_in_expected", exp_io.size() != 0, 1);
        if (exp_io.size() != 0) begin
          e = exp_io.pop_front();
          chk("io_addr", bus.io_address, e.a);
          chk("io_data", io_bus, e.d);
        end
      end
      if (bus.rd_valid && bus.rd_ready) begin
        chk("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) chk("rd_data", bus.rd_data, exp_rd.pop_front());
      end
      if (bus.done) begin
        chk("done_expected", exp_done.size() != 0, 1);
        chk("done_busy", bus.busy, 0);
        if (exp_done.size() != 0)
          if (exp_done.pop_front() > 0 && cur_write) chk("done_latency", cyc - last_in_cyc, 1);
      end
    end
  end

  task automatic issue(input logic wr, input word_t base, input word_t len, input word_t d[$]);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("cmd_ready", bus.cmd_ready, 1);
    cur_write = wr;
    for (int i = 0; i < int'(len); i++) begin
      word_t a;
      a = base + word_t'(i);
      if (wr) begin
        exp_io.push_back({a, d[i]});
        ref_mem[a] = d[i];
      end else exp_rd.push_back(ref_mem[a]);
    end
    exp_done.push_back(int'(len));
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_base = base;
    bus.cmd_len = len;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send(input word_t d[$], input int max_gap);
    foreach (d[i]) begin
      int n;
      n = 0;
      bus.wr_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      bus.wr_valid = 1'b1;
      bus.wr_data = d[i];
      @(negedge clk);
      while (!bus.wr_ready && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("wr_accept", bus.wr_ready, 1);
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_done.size() != 0 || exp_rd.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_outstanding", exp_done.size() + exp_rd.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    word_t d [$];
    word_t old1, old2, base;
    int n, len;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_base = '0;
    bus.cmd_len = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    #12;
    chk_reset("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("post_reset");

    // load 5,6,7 at 20..22
    d = '{word_t'(5), word_t'(6), word_t'(7)};
    issue(1'b1, word_t'(20), word_t'(3), d);
    send(d, 0);
    wait_done(200);
    chk("mem20", mem[20], 5);
    chk("mem21", mem[21], 6);
    chk("mem22", mem[22], 7);

    // dump two words back, each word takes two slots
    n = slot_cnt;
    issue(1'b0, word_t'(20), word_t'(2), d);
    wait_done(200);
    chk("rd_slot_count", slot_cnt - n, 4);

    // write with host data held back for three slots
    d = '{word_t'($urandom), word_t'($urandom)};
    issue(1'b1, word_t'(100), word_t'(2), d);
    n = slot_cnt;
    for (int k = 0; k < 100 && slot_cnt - n < 3; k++) begin
      @(posedge clk);
      #1;
    end
    chk("gap_slots_seen", slot_cnt - n >= 3, 1);
    chk("gap_dir", bus.io_bus_direction, IO_OUT);
    send(d, 0);
    wait_done(200);

    // wrapping read that stalls on a full read FIFO
    rd_mode = 0;
    issue(1'b0, 16'hFFFF, word_t'(6), d);
    repeat (80) @(posedge clk);
    #1;
    chk("stall_busy", bus.busy, 1);
    chk("stall_rd_valid", bus.rd_valid, 1);
    chk("stall_pending", exp_rd.size(), 6);
    rd_mode = 1;
    wait_done(400);

    // zero-length command
    n = slot_cnt;
    issue(1'b0, word_t'(50), word_t'(0), d);
    @(negedge clk);
    chk("len0_done", bus.done, 1);
    chk("len0_busy", bus.busy, 0);
    chk("len0_dir", bus.io_bus_direction, IO_OUT);
    @(posedge clk);
    #1;
    wait_done(10);
    repeat (10) @(posedge clk);
    #1;
    chk("len0_slots", slot_cnt - n, 0);

    // reset in the middle of a three-word write
    io_period = 4;
    d = '{word_t'($urandom), word_t'($urandom), word_t'($urandom)};
    old1 = ref_mem[16'h0201];
    old2 = ref_mem[16'h0202];
    issue(1'b1, 16'h0200, word_t'(3), d);
    send(d, 0);
    for (int k = 0; k < 100 && exp_io.size() > 2; k++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_first_written", exp_io.size(), 2);
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    exp_io.delete();
    exp_done.delete();
    ref_mem[16'h0201] = old1;
    ref_mem[16'h0202] = old2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 16'h0200, word_t'(3), d);
    wait_done(300);

    // random load/dump round trips
    for (int t = 0; t < 8; t++) begin
      base = word_t'($urandom);
      len = $urandom_range(1, 7);
      io_period = $urandom_range(2, 5);
      rd_mode = 2;
      d.delete();
      repeat (len) d.push_back(word_t'($urandom));
      issue(1'b1, base, word_t'(len), d);
      send(d, 3);
      wait_done(2000);
      issue(1'b0, base, word_t'(len), d);
      wait_done(2000);
    end
    chk("io_left", exp_io.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
